// File: rtl/usb_pkg.sv
// usb_pkg: shared definitions for the host-side USB transaction sequencer.
//   - 3-bit packet codes used on both rx_packet (host RX) and tx_packet (host TX)
//   - xfer_status_e: per-transfer completion status
//   - state_e: sequencer FSM states
package usb_pkg;

  localparam logic [2:0] PidIdle = 3'b000;
  localparam logic [2:0] PidData = 3'b001;
  localparam logic [2:0] PidOut  = 3'b010;
  localparam logic [2:0] PidIn   = 3'b011;
  localparam logic [2:0] PidAck  = 3'b100;
  localparam logic [2:0] PidNak  = 3'b101;
  localparam logic [2:0] PidBad  = 3'b110;

  typedef enum logic [1:0] {
    XferOk      = 2'b00,
    XferNak     = 2'b01,
    XferBad     = 2'b10,
    XferTimeout = 2'b11
  } xfer_status_e;

  typedef enum logic [3:0] {
    StIdle,
    StLoadWait,
    StToken,
    StTokenWait,
    StDataTx,
    StDataWait,
    StWaitHs,
    StWaitData,
    StRxData,
    StSendAck,
    StAckWait,
    StDone
  } state_e;

  // Token PID for a transfer direction: 0 = OUT, 1 = IN.
  function automatic logic [2:0] token_pid(input logic dir);
    return dir ? PidIn : PidOut;
  endfunction

endpackage

// File: rtl/resp_timer.sv
// resp_timer: 8-bit response wait timer.
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : clear the count (takes priority over enable)
//   enable     : count one cycle of waiting
//   expired    : high in the waiting cycle in which the count reaches TIMEOUT_CYCLES,
//                so a wait that is not answered lasts exactly TIMEOUT_CYCLES cycles
module resp_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/usb_host_sequencer.sv
// usb_host_sequencer: host-side transaction sequencer (one transfer per command).
// Sequences token/DATA/ACK on the host TX for OUT and IN transfers, interprets the
// endpoint reply reported by the host RX and reports one status per transfer.
//   clk, n_rst        : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake; cmd_dir (0 OUT, 1 IN), cmd_size (OUT bytes)
//   buffer_occupancy  : bytes currently in the host data buffer
//   rx_packet         : packet code reported by the host RX
//   tx_done           : host TX finished the current packet
//   tx_packet         : packet code for the host TX (000 = nothing)
//   d_mode            : 1 while the host owns the link
//   clear             : one-cycle host buffer flush
//   xfer_done         : one-cycle end-of-transfer pulse; xfer_status held until the next one
// Optional feature macro HOST_TIMEOUT_EN: abort WAIT_HS/WAIT_DATA after TIMEOUT_CYCLES.
module usb_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic [6:0] cmd_size,
  input  logic [6:0] buffer_occupancy,
  input  logic [2:0] rx_packet,
  input  logic       tx_done,
  output logic [2:0] tx_packet,
  output logic       d_mode,
  output logic       clear,
  output logic       xfer_done,
  output logic [1:0] xfer_status
);

  import usb_pkg::*;

  state_e       state_q, state_d;
  logic         dir_q, dir_d;
  logic [6:0]   size_q, size_d;
  xfer_status_e status_q, status_d;
  logic         clear_d;
  logic [2:0]   tx_packet_q, tx_packet_d;
  logic         d_mode_q, d_mode_d;
  logic         clear_q;
  logic         xfer_done_q, xfer_done_d;
  logic         cmd_ready_q, cmd_ready_d;
  logic         timer_expired;

`ifdef HOST_TIMEOUT_EN
  logic timer_load;
  logic timer_en;

  // Clear on the edge that enters a response wait; count while sitting in one.
  assign timer_load = ((state_d == StWaitHs) || (state_d == StWaitData)) && (state_d != state_q);
  assign timer_en   = (state_q == StWaitHs) || (state_q == StWaitData);

  resp_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_resp_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (timer_load),
    .enable  (timer_en),
    .expired (timer_expired)
  );
`else
  // No timer in this build: response waits never expire.
  assign timer_expired = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    size_d   = size_q;
    status_d = status_q;
    clear_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          dir_d   = cmd_dir;
          size_d  = cmd_size;
          state_d = cmd_dir ? StToken : StLoadWait;
        end
      end
      StLoadWait: begin
        if (buffer_occupancy == size_q) state_d = StToken;
      end
      StToken: state_d = StTokenWait;
      StTokenWait: begin
        if (tx_done) state_d = dir_q ? StWaitData : StDataTx;
      end
      StDataTx: state_d = StDataWait;
      StDataWait: begin
        if ((buffer_occupancy == 7'd0) && tx_done) state_d = StWaitHs;
      end
      StWaitHs: begin
        // A received packet takes priority over timer expiry.
        case (rx_packet)
          PidIdle: begin
            if (timer_expired) begin
              state_d  = StDone;
              status_d = XferTimeout;
            end
          end
          PidAck: begin
            state_d  = StDone;
            status_d = XferOk;
          end
          PidNak: begin
            state_d  = StDone;
            status_d = XferNak;
          end
          default: begin
            state_d  = StDone;
            status_d = XferBad;
          end
        endcase
      end
      StWaitData: begin
        case (rx_packet)
          PidIdle: begin
            if (timer_expired) begin
              state_d  = StDone;
              status_d = XferTimeout;
              clear_d  = 1'b1;
            end
          end
          PidData: state_d = StRxData;
          PidNak: begin
            state_d  = StDone;
            status_d = XferNak;
          end
          default: begin
            state_d  = StDone;
            status_d = XferBad;
          end
        endcase
      end
      StRxData: begin
        // Wait for end of packet; a corrupted payload is flushed and not acknowledged.
        if (rx_packet == PidIdle) begin
          state_d = StSendAck;
        end else if (rx_packet == PidBad) begin
          state_d  = StDone;
          status_d = XferBad;
          clear_d  = 1'b1;
        end
      end
      StSendAck: state_d = StAckWait;
      StAckWait: begin
        if (tx_done) begin
          state_d  = StDone;
          status_d = XferOk;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so registered outputs move with the state.
  always_comb begin
    tx_packet_d = PidIdle;
    unique case (state_d)
      StToken:   tx_packet_d = token_pid(dir_d);
      StDataTx:  tx_packet_d = PidData;
      StSendAck: tx_packet_d = PidAck;
      default:   tx_packet_d = PidIdle;
    endcase
    d_mode_d    = (state_d == StToken)  || (state_d == StTokenWait) ||
                  (state_d == StDataTx) || (state_d == StDataWait)  ||
                  (state_d == StSendAck) || (state_d == StAckWait);
    xfer_done_d = (state_d == StDone);
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      size_q      <= '0;
      status_q    <= XferOk;
      tx_packet_q <= PidIdle;
      d_mode_q    <= 1'b0;
      clear_q     <= 1'b0;
      xfer_done_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      size_q      <= size_d;
      status_q    <= status_d;
      tx_packet_q <= tx_packet_d;
      d_mode_q    <= d_mode_d;
      clear_q     <= clear_d;
      xfer_done_q <= xfer_done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign tx_packet   = tx_packet_q;
  assign d_mode      = d_mode_q;
  assign clear       = clear_q;
  assign xfer_done   = xfer_done_q;
  assign xfer_status = status_q;

endmodule

// File: doc/usb_host_sequencer.md
# usb_host_sequencer

Host-side transaction sequencer for the USB-style link on the far side of the endpoint protocol controller. Accepts one transfer command from the host application. Drives the host TX with the token/DATA/ACK sequence for OUT (host→endpoint) and IN (endpoint→host) transactions, and interprets the endpoint's handshake or data packets reported by the host RX. Reports one status per transfer and owns the link direction (d_mode) while a transaction is active.

## Interface
- TIMEOUT_CYCLES, 255: response wait limit in clk cycles. Used only with HOST_TIMEOUT_EN.
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_dir  in  1  0 = OUT, 1 = IN; sampled at accept
- cmd_size  in  7  OUT payload byte count; sampled at accept; ignored for IN
- buffer_occupancy  in  7  bytes currently in host data buffer
- rx_packet  in  3  from host RX: 000 IDLE, 001 DATA, 010 OUT, 011 IN, 100 ACK, 101 NAK, 110 BAD
- tx_done  in  1  host TX finished current packet
- tx_packet  out  3  to host TX, same encoding; 000 = nothing to send
- d_mode  out  1  1 = host transmitting, 0 = listening
- clear  out  1  one-cycle pulse: flush host data buffer
- xfer_done  out  1  one-cycle pulse at transfer end
- xfer_status  out  2  00 OK, 01 NAK, 10 BAD, 11 TIMEOUT; valid with xfer_done and held until next xfer_done

## Operation
- Moore FSM. All outputs registered, decoded from the next state, so they change together with the state register.
- States and transitions:
  - IDLE: on accept → LOAD_WAIT if OUT, → TOKEN if IN.
  - LOAD_WAIT: wait for buffer_occupancy == latched size → TOKEN.
  - TOKEN: tx_packet = 010 for OUT or 011 for IN, for one cycle → TOKEN_WAIT.
  - TOKEN_WAIT: on tx_done → DATA_TX if OUT, → WAIT_DATA if IN.
  - DATA_TX: tx_packet = 001 for one cycle → DATA_WAIT.
  - DATA_WAIT: on buffer_occupancy == 0 && tx_done → WAIT_HS.
  - WAIT_HS: ACK → DONE(OK); NAK → DONE(NAK); BAD or any other non-IDLE code → DONE(BAD).
  - WAIT_DATA: DATA → RX_DATA; NAK → DONE(NAK); other non-IDLE → DONE(BAD).
  - RX_DATA: IDLE → SEND_ACK; BAD → DONE(BAD) with clear pulse, no ACK sent.
  - SEND_ACK: tx_packet = 100 for one cycle → ACK_WAIT.
  - ACK_WAIT: on tx_done → DONE(OK).
  - DONE: xfer_done = 1 for one cycle → IDLE.
- d_mode = 1 in TOKEN, TOKEN_WAIT, DATA_TX, DATA_WAIT, SEND_ACK, ACK_WAIT; 0 elsewhere.
- Priority in WAIT_* states: the rx_packet decode wins over timeout expiry in the same cycle.
- tx_done outside a *_WAIT state is ignored.

## Timing
- Reset: state IDLE, cmd_ready 0 for the reset cycle then 1, tx_packet 000, d_mode 0, clear 0, xfer_done 0, xfer_status 00, timer 0.
- Accept → tx_packet token visible: 1 cycle for IN; for OUT, 1 cycle after occupancy match.
- Last response/tx_done edge → xfer_done: 1 cycle for the DONE entry plus the registered output (xfer_done high in the cycle after entering DONE's next-state decode).
- Reset mid-transfer aborts immediately. No xfer_done is issued; xfer_status returns to 00.
- cmd_valid while not IDLE is ignored; the command must be held by the source.

## Configuration
- HOST_TIMEOUT_EN defined:
  - 8-bit counter clears on entry to WAIT_HS/WAIT_DATA and increments each cycle there.
  - Reaching TIMEOUT_CYCLES → DONE(TIMEOUT). In WAIT_DATA this also pulses clear.
- HOST_TIMEOUT_EN undefined: no counter; WAIT states wait indefinitely; status 11 is never produced.

## Structure
- Shared package usb_pkg: rx/tx PID localparams (3-bit codes above), xfer_status enum, state typedef.
- Sub-module resp_timer (load, enable, expired), instantiated only under HOST_TIMEOUT_EN.

## Test plan
- OUT, size 8, occupancy 8, tx_done after each packet, ACK → tx_packet sequence 010 then 001; xfer_status 00; d_mode drops on WAIT_HS entry.
- OUT, size 4, occupancy held at 2 for 10 cycles then 4 → no token until the match; token 1 cycle after the match.
- IN, endpoint returns DATA then IDLE → tx_packet 100 sent; xfer_status 00.
- IN, endpoint returns DATA then BAD → clear pulse, no 100 on tx_packet, xfer_status 10.
- OUT answered with NAK → xfer_status 01; next command accepted from IDLE.
- HOST_TIMEOUT_EN, TIMEOUT_CYCLES = 20, IN with no response → xfer_done at timer expiry, status 11, clear pulse; reset asserted mid-wait → all outputs at reset values.
